// File: rtl/vnsr_pack_pkg.sv
// vnsr_pack_pkg: shared definitions for the narrowing right-shift pack unit.
// Holds the destination SEW codes, the pack state encoding and a helper that
// returns how many low bits of a shift slot are meaningful for a given SEW.
// The optional clipping build is selected with the VNCLIP_EN macro.
package vnsr_pack_pkg;

    // Destination element width codes carried on the sew input
    localparam logic [2:0] SEW8  = 3'b000;
    localparam logic [2:0] SEW16 = 3'b001;
    localparam logic [2:0] SEW32 = 3'b010;

    // EMPTY: no half word staged; HALF: low half staged, waiting for beat 1
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // Shift amount width is log2 of the wide (2*SEW) element width
    function automatic int shamtWidth(input logic [2:0] sewCode);
        case (sewCode)
            SEW8:    return 4;
            SEW16:   return 5;
            SEW32:   return 6;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vnsr_pack_slice.sv
// vnsr_slice: purely combinational narrowing shifter for one input beat.
// Every 2*SEW element of the beat is shifted right (logical or arithmetic)
// and narrowed to SEW bits; the narrowed elements are packed into a slice
// half the datapath width. All three legal widths are computed in parallel
// and the live sew selects one; illegal codes produce an all-zero slice.
// With VNCLIP_EN defined, each shifted element can saturate instead of
// truncating, and o_sat reports whether any element of the slice saturated.
module vnsr_slice
    import vnsr_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]   i_operand_1,
    input  logic [DATA_WIDTH-1:0]   i_operand_2,
    input  logic [2:0]              i_sew,
    input  logic                    i_arith,
`ifdef VNCLIP_EN
    input  logic                    i_clip,
    output logic                    o_sat,
`endif
    output logic [DATA_WIDTH/2-1:0] o_slice
);

    localparam int HALF_W = DATA_WIDTH / 2;

    logic [2:0][HALF_W-1:0] w_cand;
`ifdef VNCLIP_EN
    logic [2:0]             w_satAny;
`endif

    genvar gs, ge;
    for (gs = 0; gs < 3; gs++) begin : g_sew
        localparam int NW  = 8 << gs;
        localparam int EW  = 2 * NW;
        localparam int NE  = DATA_WIDTH / EW;
        localparam int SAW = shamtWidth(3'(gs));
`ifdef VNCLIP_EN
        logic [NE-1:0] w_eSat;
`endif
        for (ge = 0; ge < NE; ge++) begin : g_elem
            logic signed [EW-1:0] w_elem;
            logic [SAW-1:0]       w_amt;
            logic [EW-1:0]        w_shifted;
            logic                 w_unusedBits;

            assign w_elem    = i_operand_2[ge*EW +: EW];
            assign w_amt     = i_operand_1[ge*EW +: SAW];
            assign w_shifted = i_arith ? (w_elem >>> w_amt) : (w_elem >> w_amt);
`ifdef VNCLIP_EN
            logic w_overU;
            logic w_overS;
            assign w_overU      = |w_shifted[EW-1:NW];
            assign w_overS      = !((&w_shifted[EW-1:NW-1]) || !(|w_shifted[EW-1:NW-1]));
            assign w_eSat[ge]   = i_clip && (i_arith ? w_overS : w_overU);
            assign w_cand[gs][ge*NW +: NW] =
                !w_eSat[ge] ? w_shifted[NW-1:0] :
                i_arith     ? (w_shifted[EW-1] ? {1'b1, {(NW-1){1'b0}}} : {1'b0, {(NW-1){1'b1}}}) :
                              {NW{1'b1}};
            assign w_unusedBits = ^i_operand_1[ge*EW+SAW +: EW-SAW];
`else
            assign w_cand[gs][ge*NW +: NW] = w_shifted[NW-1:0];
            assign w_unusedBits = ^{i_operand_1[ge*EW+SAW +: EW-SAW], w_shifted[EW-1:NW]};
`endif
        end
`ifdef VNCLIP_EN
        assign w_satAny[gs] = |w_eSat;
`endif
    end

    // Pick the candidate slice (and saturation flag) for the destination SEW
    always_comb begin
        o_slice = '0;
`ifdef VNCLIP_EN
        o_sat   = 1'b0;
`endif
        case (i_sew)
            SEW8: begin
                o_slice = w_cand[0];
`ifdef VNCLIP_EN
                o_sat   = w_satAny[0];
`endif
            end
            SEW16: begin
                o_slice = w_cand[1];
`ifdef VNCLIP_EN
                o_sat   = w_satAny[1];
`endif
            end
            SEW32: begin
                o_slice = w_cand[2];
`ifdef VNCLIP_EN
                o_sat   = w_satAny[2];
`endif
            end
            default: o_slice = '0;
        endcase
    end

endmodule

// File: rtl/vnsr_pack.sv
// vnsr_pack: narrowing right shift (vnsrl / vnsra) with two-beat packing.
// Each accepted beat is narrowed to a half-width slice by vnsr_slice. The
// first beat of a pair is staged in the low half; the second beat completes
// the word in the high half. A final beat arriving with nothing staged is
// emitted alone with a zero upper half. The second beat of a pair reuses the
// SEW/mode captured with the first beat.
// Optional VNCLIP_EN build adds the clip input and the sticky sat output.
module vnsr_pack
    import vnsr_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  arith,
    input  logic [2:0]            sew,
`ifdef VNCLIP_EN
    input  logic                  clip,
    output logic                  sat,
`endif
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int HALF_W = DATA_WIDTH / 2;

    pack_state_t       r_state;
    logic [HALF_W-1:0] r_staged;
    logic [2:0]        r_sew;
    logic              r_arith;
`ifdef VNCLIP_EN
    logic              r_clip;
    logic              r_stagedSat;
    logic              w_clip;
    logic              w_sliceSat;
`endif

    logic              w_accept;
    logic              w_load;
    logic [2:0]        w_sew;
    logic              w_arith;
    logic [HALF_W-1:0] w_slice;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && ((r_state == HALF) || in_last);
    assign w_sew    = (r_state == HALF) ? r_sew   : sew;
    assign w_arith  = (r_state == HALF) ? r_arith : arith;
`ifdef VNCLIP_EN
    assign w_clip   = (r_state == HALF) ? r_clip  : clip;
`endif

    vnsr_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
        .i_operand_1 (operand_1),
        .i_operand_2 (operand_2),
        .i_sew       (w_sew),
        .i_arith     (w_arith),
`ifdef VNCLIP_EN
        .i_clip      (w_clip),
        .o_sat       (w_sliceSat),
`endif
        .o_slice     (w_slice)
    );

    // Pair tracking: stage the first slice and its mode, release on the second
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_staged    <= '0;
            r_sew       <= SEW8;
            r_arith     <= 1'b0;
`ifdef VNCLIP_EN
            r_clip      <= 1'b0;
            r_stagedSat <= 1'b0;
`endif
        end else if (w_accept) begin
            if (r_state == HALF) begin
                r_state <= EMPTY;
            end else if (!in_last) begin
                r_state     <= HALF;
                r_staged    <= w_slice;
                r_sew       <= sew;
                r_arith     <= arith;
`ifdef VNCLIP_EN
                r_clip      <= clip;
                r_stagedSat <= w_sliceSat;
`endif
            end
        end
    end

    // Output word register: load a completed word, otherwise drain on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            result    <= '0;
`ifdef VNCLIP_EN
            sat       <= 1'b0;
`endif
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_last  <= in_last;
            result    <= (r_state == HALF) ? {w_slice, r_staged} : {{HALF_W{1'b0}}, w_slice};
`ifdef VNCLIP_EN
            sat       <= ((r_state == HALF) && r_stagedSat) || w_sliceSat;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vnsr_pack.sv
// tb_vnsr_pack: scoreboard bench for vnsr_pack (DATA_WIDTH = 64).
// Accepted beats feed an arithmetic reference model that pushes expected
// words; a monitor pops and compares on every output handshake.
// Handles the VNCLIP_EN build when the macro is defined.
module tb_vnsr_pack;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic          arith;
    logic [2:0]    sew;
    logic [DW-1:0] operand_1;
    logic [DW-1:0] operand_2;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] result;
`ifdef VNCLIP_EN
    logic          clip;
    logic          sat;
`endif

    typedef struct {
        logic [63:0] word;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monEntry;
    int          nVectors = 0;
    int          nMiscompares = 0;
    bit          readyRandom = 1'b0;
    bit          mHalf = 1'b0;
    logic [31:0] mStaged;
    logic [2:0]  mSew;
    bit          mArith;
    bit          mClip;
    bit          mSat;
    bit          useOverride = 1'b0;
    logic [63:0] overrideWord;
    int          dummyWaits;

    always #5 clk = ~clk;

    vnsr_pack #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .arith     (arith),
        .sew       (sew),
`ifdef VNCLIP_EN
        .clip      (clip),
        .sat       (sat),
`endif
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .result    (result)
    );

    // Reference: narrow every wide element with plain integer arithmetic
    function automatic logic [31:0] refSlice(input logic [63:0] op1, input logic [63:0] op2,
                                             input logic [2:0] sewCode, input bit isArith,
                                             input bit doClip, output bit anySat);
        int nw;
        int ew;
        int amt;
        longint unsigned slot;
        logic [31:0] acc;
        logic signed [127:0] elem;
        logic signed [127:0] shifted;
        logic signed [127:0] lo;
        logic signed [127:0] hi;
        anySat = 1'b0;
        acc = '0;
        case (sewCode)
            3'd0: nw = 8;
            3'd1: nw = 16;
            3'd2: nw = 32;
            default: return 32'h0;
        endcase
        ew = 2 * nw;
        for (int i = 0; i < 64 / ew; i++) begin
            elem = (op2 >> (i * ew)) & ((128'sd1 <<< ew) - 128'sd1);
            slot = op1 >> (i * ew);
            amt  = int'(slot % longint'(ew));
            if (isArith && elem >= (128'sd1 <<< (ew - 1)))
                elem = elem - (128'sd1 <<< ew);
            shifted = elem >>> amt;
            if (doClip) begin
                if (isArith) begin
                    lo = -(128'sd1 <<< (nw - 1));
                    hi = (128'sd1 <<< (nw - 1)) - 128'sd1;
                end else begin
                    lo = 128'sd0;
                    hi = (128'sd1 <<< nw) - 128'sd1;
                end
                if (shifted > hi) begin
                    shifted = hi;
                    anySat = 1'b1;
                end else if (shifted < lo) begin
                    shifted = lo;
                    anySat = 1'b1;
                end
            end
            acc = acc | (32'(shifted & ((128'sd1 <<< nw) - 128'sd1)) << (i * nw));
        end
        return acc;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic pushWord(input logic [63:0] word, input bit last, input bit s);
        exp_t e;
        e.word = useOverride ? overrideWord : word;
        e.last = last;
        e.sat  = s;
        useOverride = 1'b0;
        expQ.push_back(e);
    endtask

    // Model of one accepted beat: stage a first half or complete a word
    task automatic modelAccept(input logic [63:0] op1, input logic [63:0] op2, input logic [2:0] s,
                               input bit a, input bit c, input bit last);
        logic [31:0] sl;
        bit          st;
        if (!mHalf) begin
            sl = refSlice(op1, op2, s, a, c, st);
            if (last) begin
                pushWord({32'h0, sl}, 1'b1, st);
            end else begin
                mHalf = 1'b1;
                mStaged = sl;
                mSew = s;
                mArith = a;
                mClip = c;
                mSat = st;
            end
        end else begin
            sl = refSlice(op1, op2, mSew, mArith, mClip, st);
            pushWord({sl, mStaged}, last, st || mSat);
            mHalf = 1'b0;
        end
    endtask

    // Present one beat and hold it until accepted; leaves time at posedge+1
    task automatic applyStimulus(input logic [63:0] op1, input logic [63:0] op2, input logic [2:0] s,
                                 input bit a, input bit c, input bit last, output int waits);
        bit done;
        operand_1 = op1;
        operand_2 = op2;
        sew = s;
        arith = a;
        in_last = last;
`ifdef VNCLIP_EN
        clip = c;
`endif
        in_valid = 1'b1;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                modelAccept(op1, op2, s, a, c, last);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL accept_timeout: actual in_ready 0 for %0d cycles required 1", waits);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while (expQ.size() != 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (expQ.size() != 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL drain_timeout: actual %0d words outstanding required 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Random consumer backpressure when enabled
    always @(posedge clk) begin
        #2;
        if (readyRandom) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every handshaken output word against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_word: actual %h required no word", result);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("result", result, monEntry.word);
                checkOutput("out_last", 64'(out_last), 64'(monEntry.last));
`ifdef VNCLIP_EN
                checkOutput("sat", 64'(sat), 64'(monEntry.sat));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        logic [2:0]  rs;
        bit          ra;
        bit          rc;
        bit          rl;
        int          waits;

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        arith = 1'b0;
        sew = 3'd0;
        operand_1 = '0;
        operand_2 = '0;
        out_ready = 1'b0;
`ifdef VNCLIP_EN
        clip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_last", 64'(out_last), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Logical narrow pair
        applyStimulus(64'h0004_0004_0004_0004, 64'h8000_1234_00FF_0100, 3'd0, 1'b0, 1'b0, 1'b0, dummyWaits);
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0023_0F10;
        applyStimulus(64'h0004_0004_0004_0004, 64'h0, 3'd0, 1'b0, 1'b0, 1'b1, dummyWaits);
        waitDrain();

        // Arithmetic versus logical on 16'h8000 >> 12
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0000_00F8;
        applyStimulus(64'h000C, 64'h8000, 3'd0, 1'b1, 1'b0, 1'b1, dummyWaits);
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0000_0008;
        applyStimulus(64'h000C, 64'h8000, 3'd0, 1'b0, 1'b0, 1'b1, dummyWaits);
        waitDrain();

        // Shift amount masking: 0x24 with a 5-bit mask shifts by 4
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0000_0123;
        applyStimulus(64'h0000_0024, 64'h0000_1230, 3'd1, 1'b0, 1'b0, 1'b1, dummyWaits);
        waitDrain();

        // Backpressure: word held, in_ready low, result stable
        out_ready = 1'b0;
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_AABB_CCDD;
        applyStimulus(64'h0, 64'h00AA_00BB_00CC_00DD, 3'd0, 1'b0, 1'b0, 1'b1, dummyWaits);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_result", result, 64'h0000_0000_AABB_CCDD);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(64'h0, 64'h0011_0022_0033_0044, 3'd0, 1'b0, 1'b0, 1'b0, waits);
        checkOutput("bp_same_cycle_accept", 64'(waits), 64'd0);

        // Second beat uses latched sew, not the live value
        useOverride = 1'b1;
        overrideWord = 64'h0204_0608_1122_3344;
        applyStimulus(64'h0, 64'h0102_0304_0506_0708, 3'd2, 1'b1, 1'b0, 1'b1, dummyWaits);
        waitDrain();

        // Reset while a half is staged
        applyStimulus(64'h0, 64'h00EE_00EE_00EE_00EE, 3'd0, 1'b0, 1'b0, 1'b0, dummyWaits);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mHalf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(64'h0, 64'h0001_0002_0003_0004, 3'd0, 1'b0, 1'b0, 1'b0, dummyWaits);
        useOverride = 1'b1;
        overrideWord = 64'h0506_0708_0102_0304;
        applyStimulus(64'h0, 64'h0005_0006_0007_0008, 3'd0, 1'b0, 1'b0, 1'b1, dummyWaits);
        waitDrain();

`ifdef VNCLIP_EN
        // Saturating narrow, unsigned and signed
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0000_00FF;
        applyStimulus(64'h0, 64'h0300, 3'd0, 1'b0, 1'b1, 1'b1, dummyWaits);
        useOverride = 1'b1;
        overrideWord = 64'h0000_0000_0000_0080;
        applyStimulus(64'h0, 64'hFE00, 3'd0, 1'b1, 1'b1, 1'b1, dummyWaits);
        waitDrain();
`endif

        // Randomized traffic with random consumer stalls
        readyRandom = 1'b1;
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            rs = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ra = 1'($urandom_range(0, 1));
`ifdef VNCLIP_EN
            rc = 1'($urandom_range(0, 1));
`else
            rc = 1'b0;
`endif
            rl = ($urandom_range(0, 2) == 0);
            applyStimulus(r1, r2, rs, ra, rc, rl, dummyWaits);
        end
        readyRandom = 1'b0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;
        if (mHalf) begin
            @(posedge clk);
            #1;
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 3'd1, 1'b0, 1'b0, 1'b1, dummyWaits);
        end
        waitDrain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
